pi_hit_accumulator: RTL and testbench

- Consumer of the circle checker's output stream (`output_valid`/`dout`).
- Counts samples and inside-circle hits over a batch of exactly 2^LOG2_SAMPLES samples.
- Produces a fixed-point pi estimate, 4*hits/N in Q4.28, and presents it to the downstream reader (UART/AXI register stage) over a valid/ready handshake.
- Sits between the checker and the result/readout logic; `busy` gates the upstream point generator.

---
 rtl/pi_est_pkg.sv | 19 +
 rtl/pi_sat_counter.sv | 26 ++
 rtl/pi_hit_accumulator.sv | 130 +++++++++++++
 tb/tb_pi_hit_accumulator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_est_pkg.sv
// Shared types and constants for the pi-estimation datapath.
package pi_est_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned FRAC_BITS = 28;
  localparam int unsigned PI_W      = 32;
  localparam int unsigned DROP_W    = 16;

  // 4*hits/N in Q4.28 collapses to a left shift by (FRAC_BITS + 2 - log2 N).
  function automatic int unsigned pi_shift(input int unsigned log2_samples);
    return (FRAC_BITS + 2) - log2_samples;
  endfunction

endpackage

// File: rtl/pi_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pi_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pi_hit_accumulator.sv
// Batch hit accumulator producing a Q4.28 pi estimate over 2^LOG2_SAMPLES samples.
// Optional dropped-sample counter enabled by PI_HIT_ACCUMULATOR_DROP_COUNT_EN.
module pi_hit_accumulator
  import pi_est_pkg::*;
#(
  parameter int unsigned LOG2_SAMPLES = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic                    in_hit,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [LOG2_SAMPLES:0]   hit_count,
  output logic [PI_W-1:0]         pi_estimate
`ifdef PI_HIT_ACCUMULATOR_DROP_COUNT_EN
  ,
  output logic [DROP_W-1:0]       drop_count
`endif
);

  localparam int unsigned CNT_W = LOG2_SAMPLES;
  localparam int unsigned HIT_W = LOG2_SAMPLES + 1;
  localparam int unsigned SHIFT = pi_shift(LOG2_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_CNT = {CNT_W{1'b1}};

  if ((LOG2_SAMPLES < 4) || (LOG2_SAMPLES > 30)) begin : g_bad_log2
    $error("pi_hit_accumulator: LOG2_SAMPLES must be within 4..30");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [HIT_W-1:0]   hit_acc_q, hit_acc_d;
  logic [HIT_W-1:0]   hit_count_q, hit_count_d;
  logic [PI_W-1:0]    pi_q, pi_d;
  logic [HIT_W-1:0]   hit_next;
  logic               busy_q;
  logic               result_valid_q;

  // Next-state: counters advance only in RUN; result latched on DONE entry.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    hit_acc_d    = hit_acc_q;
    hit_count_d  = hit_count_q;
    pi_d         = pi_q;
    hit_next     = hit_acc_q + HIT_W'(in_hit);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          sample_cnt_d = '0;
          hit_acc_d    = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
          hit_acc_d    = hit_next;
          if (sample_cnt_q == LAST_CNT) begin
            state_d     = DONE;
            hit_count_d = hit_next;
            pi_d        = PI_W'(hit_next) << SHIFT;
          end
        end
      end
      DONE: begin
        if (result_ready) begin
          if (start) begin
            state_d      = RUN;
            sample_cnt_d = '0;
            hit_acc_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sample_cnt_q   <= '0;
      hit_acc_q      <= '0;
      hit_count_q    <= '0;
      pi_q           <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_cnt_q   <= sample_cnt_d;
      hit_acc_q      <= hit_acc_d;
      hit_count_q    <= hit_count_d;
      pi_q           <= pi_d;
      busy_q         <= (state_d == RUN);
      result_valid_q <= (state_d == DONE);
    end
  end

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign hit_count    = hit_count_q;
  assign pi_estimate  = pi_q;

`ifdef PI_HIT_ACCUMULATOR_DROP_COUNT_EN
  logic start_accept;
  logic drop_inc;

  assign start_accept = start && ((state_q == IDLE) ||
                                  ((state_q == DONE) && result_ready));
  // Samples arriving outside RUN (idle or checker in-flight during DONE).
  assign drop_inc     = in_valid && (state_q != RUN);

  pi_sat_counter #(
    .W (DROP_W)
  ) u_drop_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start_accept),
    .inc_i   (drop_inc),
    .count_o (drop_count)
  );
`endif

endmodule

// File: tb/tb_pi_hit_accumulator.sv
// Directed bench for pi_hit_accumulator (LOG2_SAMPLES=4 and 10 instances).
module tb_pi_hit_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_hit, result_ready;
  logic        busy, result_valid;
  logic [4:0]  hit_count;
  logic [31:0] pi_estimate;

  logic        b_start, b_in_valid, b_in_hit, b_result_ready;
  logic        b_busy, b_result_valid;
  logic [10:0] b_hit_count;
  logic [31:0] b_pi_estimate;

`ifdef PI_HIT_ACCUMULATOR_DROP_COUNT_EN
  logic [15:0] drop_count;
  logic [15:0] b_drop_count;
`endif

  int checks = 0;
  int errors = 0;

  bit hit_pat[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                      1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int gaps[16]    = '{0, 3, 1, 5, 0, 2, 4, 0, 1, 5, 3, 0, 2, 1, 4, 0};

  always #5 clk = ~clk;

  pi_hit_accumulator #(.LOG2_SAMPLES(4)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_hit       (in_hit),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .hit_count    (hit_count),
    .pi_estimate  (pi_estimate)
`ifdef PI_HIT_ACCUMULATOR_DROP_COUNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  pi_hit_accumulator #(.LOG2_SAMPLES(10)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .start        (b_start),
    .in_valid     (b_in_valid),
    .in_hit       (b_in_hit),
    .busy         (b_busy),
    .result_valid (b_result_valid),
    .result_ready (b_result_ready),
    .hit_count    (b_hit_count),
    .pi_estimate  (b_pi_estimate)
`ifdef PI_HIT_ACCUMULATOR_DROP_COUNT_EN
    ,
    .drop_count   (b_drop_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_hit = 1'b0; result_ready = 1'b0;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_hit = 1'b0; b_result_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_hc", 32'(hit_count), 32'd0);
    check("rst_pi", pi_estimate, 32'd0);
    check("rst_b_rv", 32'(b_result_valid), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);

    // Batch 1: 16 back-to-back hits
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_rv_run", 32'(result_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_hit   = 1'b1;
      tick();
      if (i == 14) check("t1_rv_early", 32'(result_valid), 32'd0);
    end
    in_valid = 1'b0;
    in_hit   = 1'b0;
    check("t1_rv", 32'(result_valid), 32'd1);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_hc", 32'(hit_count), 32'd16);
    check("t1_pi", pi_estimate, 32'h4000_0000);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("t1_rv_after_hs", 32'(result_valid), 32'd0);
    check("t1_busy_after_hs", 32'(busy), 32'd0);
    check("t1_hc_held", 32'(hit_count), 32'd16);

    // Idle drops with stray result_ready
    result_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_hit   = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
    end
    result_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rv", 32'(result_valid), 32'd0);
`ifdef PI_HIT_ACCUMULATOR_DROP_COUNT_EN
    check("idle_drop", 32'(drop_count), 32'd3);
`endif

    // Batch 2: 12 hits + 4 misses with gaps, stray start mid-batch
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_busy_start", 32'(busy), 32'd1);
`ifdef PI_HIT_ACCUMULATOR_DROP_COUNT_EN
    check("t2_drop_clr", 32'(drop_count), 32'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_hit   = hit_pat[i];
      start    = (i == 5);
      tick();
      in_valid = 1'b0;
      in_hit   = 1'b0;
      start    = 1'b0;
      for (int g = 0; g < gaps[i]; g++) begin
        tick();
        check("t2_busy_gap", 32'(busy), 32'd1);
      end
    end
    check("t2_rv", 32'(result_valid), 32'd1);
    check("t2_busy_done", 32'(busy), 32'd0);
    check("t2_hc", 32'(hit_count), 32'd12);
    check("t2_pi", pi_estimate, 32'h3000_0000);

    // Stall in DONE with in-flight samples, then handshake + start together
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 2);
      in_hit   = 1'b1;
      tick();
      check("t3_rv_hold", 32'(result_valid), 32'd1);
      check("t3_hc_hold", 32'(hit_count), 32'd12);
      check("t3_pi_hold", pi_estimate, 32'h3000_0000);
    end
    in_valid = 1'b0;
    in_hit   = 1'b0;
`ifdef PI_HIT_ACCUMULATOR_DROP_COUNT_EN
    check("t3_drop", 32'(drop_count), 32'd2);
`endif
    result_ready = 1'b1;
    start        = 1'b1;
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    check("t3_busy_restart", 32'(busy), 32'd1);
    check("t3_rv_restart", 32'(result_valid), 32'd0);
`ifdef PI_HIT_ACCUMULATOR_DROP_COUNT_EN
    check("t3_drop_clr", 32'(drop_count), 32'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_hit   = ((i % 3) == 0);
      tick();
    end
    in_valid = 1'b0;
    in_hit   = 1'b0;
    check("t3_rv", 32'(result_valid), 32'd1);
    check("t3_hc", 32'(hit_count), 32'd6);
    check("t3_pi", pi_estimate, 32'h1800_0000);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("t3_rv_after_hs", 32'(result_valid), 32'd0);

    // Reset mid-batch after 7 samples
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_hit   = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_hit   = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rv", 32'(result_valid), 32'd0);
    check("t5_hc", 32'(hit_count), 32'd0);
    check("t5_pi", pi_estimate, 32'd0);
    tick();
    check("t5_busy_stay", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_hit   = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    check("t5b_rv", 32'(result_valid), 32'd1);
    check("t5b_hc", 32'(hit_count), 32'd0);
    check("t5b_pi", pi_estimate, 32'd0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // LOG2_SAMPLES=10: 804 hits of 1024 -> 804 << 20
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b_busy", 32'(b_busy), 32'd1);
    for (int i = 0; i < 1024; i++) begin
      b_in_valid = 1'b1;
      b_in_hit   = (i < 804);
      tick();
      if (i == 1022) check("b_rv_early", 32'(b_result_valid), 32'd0);
    end
    b_in_valid = 1'b0;
    b_in_hit   = 1'b0;
    check("b_rv", 32'(b_result_valid), 32'd1);
    check("b_hc", 32'(b_hit_count), 32'd804);
    check("b_pi", b_pi_estimate, 32'h3240_0000);
    b_result_ready = 1'b1;
    tick();
    b_result_ready = 1'b0;
    check("b_rv_after_hs", 32'(b_result_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
